// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame/config widths and the arbiter state encoding.
// The frame layout matches what spi_master expects on driver_data.
package spi_pkg;

  localparam int DWIDTH  = 8;
  localparam int AWIDTH  = 8;
  localparam int FRAME_W = DWIDTH + AWIDTH + 3 + 2;
  localparam int CFG_W   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts at ptr, takes the lowest set bit, then maps it back to a requester index.
module spi_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_off;

  // ptr + offset never reaches 2*NREQ, so one conditional subtract is a full modulo
  function automatic int wrap_idx(input int v);
    return (v >= NREQ) ? (v - NREQ) : v;
  endfunction

  // Rotate so that bit 0 corresponds to requester ptr
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rot[j] = req[wrap_idx(int'(ptr) + j)];
    end
  end

  // Priority-encode the rotated vector; scanning downward leaves the lowest hit
  always_comb begin
    valid = 1'b0;
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      valid = valid | w_rot[j];
      w_off = w_rot[j] ? IW'(j) : w_off;
    end
  end

  assign idx = IW'(wrap_idx(int'(w_off) + int'(ptr)));

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ requesters, with a
// per-transaction timeout and a forced idle gap so ss_n deasserts between frames.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0][FRAME_W-1:0]   req_frame,
  input  logic [NREQ-1:0][CFG_W-1:0]     req_cfg,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [DWIDTH-1:0]              rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [$clog2(NREQ)-1:0]        grant_id,
  output logic                           master_en,
  output logic [FRAME_W-1:0]             driver_data,
  output logic [CFG_W-1:0]               driver_cfg,
  input  logic                           driver_read,
  input  logic [DWIDTH-1:0]              spi_slv_read_data
);

  localparam int IW    = $clog2(NREQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [IW-1:0]    IW_LAST  = IW'(NREQ - 1);
  localparam logic [IW-1:0]    IW_ONE   = IW'(1);
  localparam logic [NREQ-1:0]  REQ_ONE  = NREQ'(1);

  arb_state_t           r_state;
  arb_state_t           w_state_next;
  logic [IW-1:0]        r_rr_ptr;
  logic [TO_W-1:0]      r_to_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [NREQ-1:0]      r_rsp_valid;
  logic [DWIDTH-1:0]    r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_busy;
  logic                 r_master_en;
  logic [IW-1:0]        r_grant_id;
  logic [FRAME_W-1:0]   r_driver_data;
  logic [CFG_W-1:0]     r_driver_cfg;
  logic [NREQ-1:0]      w_req_ready;
  logic                 w_pick_valid;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_expired;

  spi_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_expired = (r_to_cnt == TO_LAST);

  // Next-state decode and the combinational accept strobe
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state_next = ARB_BUSY;
          w_req_ready  = REQ_ONE << w_pick_idx;
        end else begin
          w_state_next = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (driver_read || w_expired) begin
          w_state_next = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
        end else begin
          w_state_next = ARB_BUSY;
        end
      end
      ARB_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = ARB_IDLE;
        end else begin
          w_state_next = ARB_GAP;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // State register; master_en/busy are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_master_en <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_master_en <= (w_state_next == ARB_BUSY);
      r_busy      <= (w_state_next != ARB_IDLE);
    end
  end

  // Payload capture, counters and response; driver_read beats a coincident timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_grant_id    <= '0;
      r_driver_data <= '0;
      r_driver_cfg  <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_driver_data <= req_frame[w_pick_idx];
            r_driver_cfg  <= req_cfg[w_pick_idx];
            r_grant_id    <= w_pick_idx;
            r_rr_ptr      <= (w_pick_idx == IW_LAST) ? '0 : (w_pick_idx + IW_ONE);
            r_to_cnt      <= '0;
          end
        end
        ARB_BUSY: begin
          r_gap_cnt <= '0;
          if (driver_read) begin
            r_rsp_data  <= spi_slv_read_data;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= REQ_ONE << r_grant_id;
          end else if (w_expired) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= REQ_ONE << r_grant_id;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        ARB_GAP: begin
          if (r_gap_cnt != GAP_LAST) begin
            r_gap_cnt <= r_gap_cnt + GAP_ONE;
          end
        end
        default: begin
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign master_en   = r_master_en;
  assign driver_data = r_driver_data;
  assign driver_cfg  = r_driver_cfg;

endmodule
